// File: rtl/axil_arb_pkg.sv
// -----------------------------------------------------------------------------
// axil_arb_pkg
//   Shared types and constants for the two-manager AXI4-Lite round-robin
//   arbiter (axil_rr_arbiter) and its picker (axil_rr_pick2).
//   No ports: package only.
// -----------------------------------------------------------------------------
package axil_arb_pkg;

  // Number of upstream managers merged onto the single downstream port.
  localparam int num_ports_lp = 2;

  // AXI-Lite protection field width.
  localparam int prot_width_lp = 3;

  // Write channel: arbitrate, forward AW+W, route B back.
  typedef enum logic [1:0] {
    e_idle,
    e_wr_busy,
    e_wr_resp
  } arb_wr_state_e;

  // Read channel: arbitrate, forward AR, route R back. Enum literals share the
  // package scope with the write enum, so the read idle state needs its own name.
  typedef enum logic [1:0] {
    e_rd_idle,
    e_rd_addr,
    e_rd_resp
  } arb_rd_state_e;

endpackage

// File: rtl/axil_rr_pick2.sv
// -----------------------------------------------------------------------------
// axil_rr_pick2
//   Combinational two-way round-robin picker.
//   req    : request vector, bit i = port i wants the channel
//   last   : id of the port granted most recently
//   gnt_v  : at least one request is present
//   gnt_id : id of the selected port (only meaningful with gnt_v)
//   A lone requester always wins; on a tie the port that did not go last wins.
// -----------------------------------------------------------------------------
module axil_rr_pick2
  import axil_arb_pkg::*;
(
  input  logic [num_ports_lp-1:0] req,
  input  logic                    last,
  output logic                    gnt_v,
  output logic                    gnt_id
);

  // NOTE: every output gets a value on every path through always_comb
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    gnt_v  = 1'b0;
    gnt_id = 1'b0;
    if (req != '0) begin
      gnt_v  = 1'b1;
      gnt_id = (req == 2'b11) ? ~last : req[1];
    end
  end

endmodule

// File: rtl/axil_rr_arbiter.sv
// -----------------------------------------------------------------------------
// axil_rr_arbiter
//   Two-manager to one-subordinate AXI4-Lite arbiter. Write and read channels
//   are arbitrated independently, each round-robin with one outstanding
//   transaction at a time.
//   clk_i, reset_i : single clock, synchronous active-high reset
//   s00_axil_*     : upstream manager 0 (this block is its subordinate)
//   s01_axil_*     : upstream manager 1
//   m00_axil_*     : downstream port to the shared subordinate
//   Address/prot/data/strb and responses pass through unmodified; ready and
//   response-valid paths are combinational through the registered grant.
// -----------------------------------------------------------------------------
module axil_rr_arbiter
  import axil_arb_pkg::*;
#(
  parameter int addr_width_p = 32,
  parameter int data_width_p = 32
) (
  input  logic                      clk_i,
  input  logic                      reset_i,

  input  logic [addr_width_p-1:0]   s00_axil_awaddr,
  input  logic [prot_width_lp-1:0]  s00_axil_awprot,
  input  logic                      s00_axil_awvalid,
  output logic                      s00_axil_awready,
  input  logic [data_width_p-1:0]   s00_axil_wdata,
  input  logic [data_width_p/8-1:0] s00_axil_wstrb,
  input  logic                      s00_axil_wvalid,
  output logic                      s00_axil_wready,
  output logic [1:0]                s00_axil_bresp,
  output logic                      s00_axil_bvalid,
  input  logic                      s00_axil_bready,
  input  logic [addr_width_p-1:0]   s00_axil_araddr,
  input  logic [prot_width_lp-1:0]  s00_axil_arprot,
  input  logic                      s00_axil_arvalid,
  output logic                      s00_axil_arready,
  output logic [data_width_p-1:0]   s00_axil_rdata,
  output logic [1:0]                s00_axil_rresp,
  output logic                      s00_axil_rvalid,
  input  logic                      s00_axil_rready,

  input  logic [addr_width_p-1:0]   s01_axil_awaddr,
  input  logic [prot_width_lp-1:0]  s01_axil_awprot,
  input  logic                      s01_axil_awvalid,
  output logic                      s01_axil_awready,
  input  logic [data_width_p-1:0]   s01_axil_wdata,
  input  logic [data_width_p/8-1:0] s01_axil_wstrb,
  input  logic                      s01_axil_wvalid,
  output logic                      s01_axil_wready,
  output logic [1:0]                s01_axil_bresp,
  output logic                      s01_axil_bvalid,
  input  logic                      s01_axil_bready,
  input  logic [addr_width_p-1:0]   s01_axil_araddr,
  input  logic [prot_width_lp-1:0]  s01_axil_arprot,
  input  logic                      s01_axil_arvalid,
  output logic                      s01_axil_arready,
  output logic [data_width_p-1:0]   s01_axil_rdata,
  output logic [1:0]                s01_axil_rresp,
  output logic                      s01_axil_rvalid,
  input  logic                      s01_axil_rready,

  output logic [addr_width_p-1:0]   m00_axil_awaddr,
  output logic [prot_width_lp-1:0]  m00_axil_awprot,
  output logic                      m00_axil_awvalid,
  input  logic                      m00_axil_awready,
  output logic [data_width_p-1:0]   m00_axil_wdata,
  output logic [data_width_p/8-1:0] m00_axil_wstrb,
  output logic                      m00_axil_wvalid,
  input  logic                      m00_axil_wready,
  input  logic [1:0]                m00_axil_bresp,
  input  logic                      m00_axil_bvalid,
  output logic                      m00_axil_bready,
  output logic [addr_width_p-1:0]   m00_axil_araddr,
  output logic [prot_width_lp-1:0]  m00_axil_arprot,
  output logic                      m00_axil_arvalid,
  input  logic                      m00_axil_arready,
  input  logic [data_width_p-1:0]   m00_axil_rdata,
  input  logic [1:0]                m00_axil_rresp,
  input  logic                      m00_axil_rvalid,
  output logic                      m00_axil_rready
);

  // ---------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------
  arb_wr_state_e wr_state_r;
  logic          wgrant_r;
  logic          last_wgrant_r;
  logic          aw_done_r;
  logic          w_done_r;

  logic          wr_pick_v;
  logic          wr_pick_id;
  logic          wr_busy;
  logic          wr_resp;
  logic          aw_hs;
  logic          w_hs;
  logic          b_hs;

  // Only awvalid requests a write grant; an early wvalid just waits.
  axil_rr_pick2 u_wr_pick (
    .req    ({s01_axil_awvalid, s00_axil_awvalid}),
    .last   (last_wgrant_r),
    .gnt_v  (wr_pick_v),
    .gnt_id (wr_pick_id)
  );

  assign wr_busy = (wr_state_r == e_wr_busy);
  assign wr_resp = (wr_state_r == e_wr_resp);
  assign aw_hs   = m00_axil_awvalid & m00_axil_awready;
  assign w_hs    = m00_axil_wvalid  & m00_axil_wready;
  assign b_hs    = m00_axil_bvalid  & m00_axil_bready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_state_r    <= e_idle;
      wgrant_r      <= 1'b0;
      last_wgrant_r <= 1'b1;   // s00 wins the first tie
      aw_done_r     <= 1'b0;
      w_done_r      <= 1'b0;
    end else begin
      case (wr_state_r)
        e_idle: begin
          if (wr_pick_v) begin
            wgrant_r   <= wr_pick_id;
            aw_done_r  <= 1'b0;
            w_done_r   <= 1'b0;
            wr_state_r <= e_wr_busy;
          end
        end
        e_wr_busy: begin
          // AW and W complete independently, in either order or together.
          aw_done_r <= aw_done_r | aw_hs;
          w_done_r  <= w_done_r  | w_hs;
          if ((aw_done_r | aw_hs) && (w_done_r | w_hs)) begin
            wr_state_r <= e_wr_resp;
          end
        end
        e_wr_resp: begin
          if (b_hs) begin
            last_wgrant_r <= wgrant_r;
            wr_state_r    <= e_idle;
          end
        end
        default: wr_state_r <= e_idle;
      endcase
    end
  end

  // Forward the granted manager's AW/W; each valid is masked once accepted.
  assign m00_axil_awaddr  = wgrant_r ? s01_axil_awaddr : s00_axil_awaddr;
  assign m00_axil_awprot  = wgrant_r ? s01_axil_awprot : s00_axil_awprot;
  assign m00_axil_awvalid = wr_busy & ~aw_done_r &
                            (wgrant_r ? s01_axil_awvalid : s00_axil_awvalid);
  assign m00_axil_wdata   = wgrant_r ? s01_axil_wdata : s00_axil_wdata;
  assign m00_axil_wstrb   = wgrant_r ? s01_axil_wstrb : s00_axil_wstrb;
  assign m00_axil_wvalid  = wr_busy & ~w_done_r &
                            (wgrant_r ? s01_axil_wvalid : s00_axil_wvalid);
  assign m00_axil_bready  = wr_resp & (wgrant_r ? s01_axil_bready : s00_axil_bready);

  assign s00_axil_awready = m00_axil_awready & wr_busy & ~aw_done_r & ~wgrant_r;
  assign s01_axil_awready = m00_axil_awready & wr_busy & ~aw_done_r &  wgrant_r;
  assign s00_axil_wready  = m00_axil_wready  & wr_busy & ~w_done_r  & ~wgrant_r;
  assign s01_axil_wready  = m00_axil_wready  & wr_busy & ~w_done_r  &  wgrant_r;
  assign s00_axil_bvalid  = m00_axil_bvalid  & wr_resp & ~wgrant_r;
  assign s01_axil_bvalid  = m00_axil_bvalid  & wr_resp &  wgrant_r;
  assign s00_axil_bresp   = m00_axil_bresp;
  assign s01_axil_bresp   = m00_axil_bresp;

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  arb_rd_state_e rd_state_r;
  logic          rgrant_r;
  logic          last_rgrant_r;

  logic          rd_pick_v;
  logic          rd_pick_id;
  logic          rd_addr;
  logic          rd_resp;
  logic          ar_hs;
  logic          r_hs;

  axil_rr_pick2 u_rd_pick (
    .req    ({s01_axil_arvalid, s00_axil_arvalid}),
    .last   (last_rgrant_r),
    .gnt_v  (rd_pick_v),
    .gnt_id (rd_pick_id)
  );

  assign rd_addr = (rd_state_r == e_rd_addr);
  assign rd_resp = (rd_state_r == e_rd_resp);
  assign ar_hs   = m00_axil_arvalid & m00_axil_arready;
  assign r_hs    = m00_axil_rvalid  & m00_axil_rready;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_state_r    <= e_rd_idle;
      rgrant_r      <= 1'b0;
      last_rgrant_r <= 1'b1;
    end else begin
      case (rd_state_r)
        e_rd_idle: begin
          if (rd_pick_v) begin
            rgrant_r   <= rd_pick_id;
            rd_state_r <= e_rd_addr;
          end
        end
        e_rd_addr: begin
          // Leaving the state on the handshake doubles as the AR done mask.
          if (ar_hs) begin
            rd_state_r <= e_rd_resp;
          end
        end
        e_rd_resp: begin
          if (r_hs) begin
            last_rgrant_r <= rgrant_r;
            rd_state_r    <= e_rd_idle;
          end
        end
        default: rd_state_r <= e_rd_idle;
      endcase
    end
  end

  assign m00_axil_araddr  = rgrant_r ? s01_axil_araddr : s00_axil_araddr;
  assign m00_axil_arprot  = rgrant_r ? s01_axil_arprot : s00_axil_arprot;
  assign m00_axil_arvalid = rd_addr & (rgrant_r ? s01_axil_arvalid : s00_axil_arvalid);
  assign m00_axil_rready  = rd_resp & (rgrant_r ? s01_axil_rready  : s00_axil_rready);

  assign s00_axil_arready = m00_axil_arready & rd_addr & ~rgrant_r;
  assign s01_axil_arready = m00_axil_arready & rd_addr &  rgrant_r;
  assign s00_axil_rvalid  = m00_axil_rvalid  & rd_resp & ~rgrant_r;
  assign s01_axil_rvalid  = m00_axil_rvalid  & rd_resp &  rgrant_r;
  assign s00_axil_rdata   = m00_axil_rdata;
  assign s01_axil_rdata   = m00_axil_rdata;
  assign s00_axil_rresp   = m00_axil_rresp;
  assign s01_axil_rresp   = m00_axil_rresp;

endmodule

// File: tb/tb_axil_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axil_rr_arbiter
//   Directed stimulus on both upstream managers, a small downstream
//   subordinate responder, and a transaction-level model of the arbiter that
//   is compared against every DUT output each cycle (sampled on negedge).
// -----------------------------------------------------------------------------
module tb_axil_rr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_i;

  // Upstream ports, indexed by manager id.
  logic [31:0] s_awaddr [2];
  logic [2:0]  s_awprot [2];
  logic        s_awvalid[2];
  logic        s_awready[2];
  logic [31:0] s_wdata  [2];
  logic [3:0]  s_wstrb  [2];
  logic        s_wvalid [2];
  logic        s_wready [2];
  logic [1:0]  s_bresp  [2];
  logic        s_bvalid [2];
  logic        s_bready [2];
  logic [31:0] s_araddr [2];
  logic [2:0]  s_arprot [2];
  logic        s_arvalid[2];
  logic        s_arready[2];
  logic [31:0] s_rdata  [2];
  logic [1:0]  s_rresp  [2];
  logic        s_rvalid [2];
  logic        s_rready [2];

  // Downstream port.
  logic [31:0] m_awaddr;  logic [2:0] m_awprot; logic m_awvalid, m_awready;
  logic [31:0] m_wdata;   logic [3:0] m_wstrb;  logic m_wvalid,  m_wready;
  logic [1:0]  m_bresp;   logic m_bvalid, m_bready;
  logic [31:0] m_araddr;  logic [2:0] m_arprot; logic m_arvalid, m_arready;
  logic [31:0] m_rdata;   logic [1:0] m_rresp;  logic m_rvalid,  m_rready;

  axil_rr_arbiter #(.addr_width_p(32), .data_width_p(32)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .s00_axil_awaddr(s_awaddr[0]), .s00_axil_awprot(s_awprot[0]),
    .s00_axil_awvalid(s_awvalid[0]), .s00_axil_awready(s_awready[0]),
    .s00_axil_wdata(s_wdata[0]), .s00_axil_wstrb(s_wstrb[0]),
    .s00_axil_wvalid(s_wvalid[0]), .s00_axil_wready(s_wready[0]),
    .s00_axil_bresp(s_bresp[0]), .s00_axil_bvalid(s_bvalid[0]), .s00_axil_bready(s_bready[0]),
    .s00_axil_araddr(s_araddr[0]), .s00_axil_arprot(s_arprot[0]),
    .s00_axil_arvalid(s_arvalid[0]), .s00_axil_arready(s_arready[0]),
    .s00_axil_rdata(s_rdata[0]), .s00_axil_rresp(s_rresp[0]),
    .s00_axil_rvalid(s_rvalid[0]), .s00_axil_rready(s_rready[0]),
    .s01_axil_awaddr(s_awaddr[1]), .s01_axil_awprot(s_awprot[1]),
    .s01_axil_awvalid(s_awvalid[1]), .s01_axil_awready(s_awready[1]),
    .s01_axil_wdata(s_wdata[1]), .s01_axil_wstrb(s_wstrb[1]),
    .s01_axil_wvalid(s_wvalid[1]), .s01_axil_wready(s_wready[1]),
    .s01_axil_bresp(s_bresp[1]), .s01_axil_bvalid(s_bvalid[1]), .s01_axil_bready(s_bready[1]),
    .s01_axil_araddr(s_araddr[1]), .s01_axil_arprot(s_arprot[1]),
    .s01_axil_arvalid(s_arvalid[1]), .s01_axil_arready(s_arready[1]),
    .s01_axil_rdata(s_rdata[1]), .s01_axil_rresp(s_rresp[1]),
    .s01_axil_rvalid(s_rvalid[1]), .s01_axil_rready(s_rready[1]),
    .m00_axil_awaddr(m_awaddr), .m00_axil_awprot(m_awprot),
    .m00_axil_awvalid(m_awvalid), .m00_axil_awready(m_awready),
    .m00_axil_wdata(m_wdata), .m00_axil_wstrb(m_wstrb),
    .m00_axil_wvalid(m_wvalid), .m00_axil_wready(m_wready),
    .m00_axil_bresp(m_bresp), .m00_axil_bvalid(m_bvalid), .m00_axil_bready(m_bready),
    .m00_axil_araddr(m_araddr), .m00_axil_arprot(m_arprot),
    .m00_axil_arvalid(m_arvalid), .m00_axil_arready(m_arready),
    .m00_axil_rdata(m_rdata), .m00_axil_rresp(m_rresp),
    .m00_axil_rvalid(m_rvalid), .m00_axil_rready(m_rready)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level view of each channel: who owns it and how far along.
  typedef struct {
    bit open;
    int port;
    bit aw_ok;
    bit w_ok;
    bit resp;
  } wr_txn_t;

  typedef struct {
    bit open;
    int port;
    bit resp;
  } rd_txn_t;

  wr_txn_t wt;
  rd_txn_t rt;
  int      last_w = 1;
  int      last_r = 1;
  bit      model_live = 0;

  function automatic int rr_pick(input bit r0, input bit r1, input int last);
    if (r0 && r1) return 1 - last;
    return r1 ? 1 : 0;
  endfunction

  task automatic compare_cycle();
    bit e;
    if (model_live) begin
      e = wt.open && !wt.resp && !wt.aw_ok && s_awvalid[wt.port];
      check("m00_awvalid", m_awvalid, e);
      if (e) begin
        check("m00_awaddr", m_awaddr, s_awaddr[wt.port]);
        check("m00_awprot", m_awprot, s_awprot[wt.port]);
      end
      e = wt.open && !wt.resp && !wt.w_ok && s_wvalid[wt.port];
      check("m00_wvalid", m_wvalid, e);
      if (e) begin
        check("m00_wdata", m_wdata, s_wdata[wt.port]);
        check("m00_wstrb", m_wstrb, s_wstrb[wt.port]);
      end
      check("m00_bready", m_bready, wt.open && wt.resp && s_bready[wt.port]);
      e = rt.open && !rt.resp && s_arvalid[rt.port];
      check("m00_arvalid", m_arvalid, e);
      if (e) begin
        check("m00_araddr", m_araddr, s_araddr[rt.port]);
        check("m00_arprot", m_arprot, s_arprot[rt.port]);
      end
      check("m00_rready", m_rready, rt.open && rt.resp && s_rready[rt.port]);
      for (int p = 0; p < 2; p++) begin
        check($sformatf("s%0d_awready", p), s_awready[p],
              wt.open && !wt.resp && !wt.aw_ok && wt.port == p && m_awready);
        check($sformatf("s%0d_wready", p), s_wready[p],
              wt.open && !wt.resp && !wt.w_ok && wt.port == p && m_wready);
        e = wt.open && wt.resp && wt.port == p && m_bvalid;
        check($sformatf("s%0d_bvalid", p), s_bvalid[p], e);
        if (e) check($sformatf("s%0d_bresp", p), s_bresp[p], m_bresp);
        check($sformatf("s%0d_arready", p), s_arready[p],
              rt.open && !rt.resp && rt.port == p && m_arready);
        e = rt.open && rt.resp && rt.port == p && m_rvalid;
        check($sformatf("s%0d_rvalid", p), s_rvalid[p], e);
        if (e) begin
          check($sformatf("s%0d_rdata", p), s_rdata[p], m_rdata);
          check($sformatf("s%0d_rresp", p), s_rresp[p], m_rresp);
        end
      end
    end
    // Advance the model to what the next edge produces.
    if (reset_i) begin
      wt = '{default: 0};
      rt = '{default: 0};
      last_w = 1;
      last_r = 1;
      model_live = 1;
    end else if (model_live) begin
      if (!wt.open) begin
        if (s_awvalid[0] || s_awvalid[1]) begin
          wt = '{default: 0};
          wt.open = 1;
          wt.port = rr_pick(s_awvalid[0], s_awvalid[1], last_w);
        end
      end else if (!wt.resp) begin
        if (m_awready && s_awvalid[wt.port]) wt.aw_ok = 1;
        if (m_wready  && s_wvalid[wt.port])  wt.w_ok  = 1;
        if (wt.aw_ok && wt.w_ok) wt.resp = 1;
      end else if (m_bvalid && s_bready[wt.port]) begin
        last_w  = wt.port;
        wt.open = 0;
      end
      if (!rt.open) begin
        if (s_arvalid[0] || s_arvalid[1]) begin
          rt = '{default: 0};
          rt.open = 1;
          rt.port = rr_pick(s_arvalid[0], s_arvalid[1], last_r);
        end
      end else if (!rt.resp) begin
        if (m_arready && s_arvalid[rt.port]) rt.resp = 1;
      end else if (m_rvalid && s_rready[rt.port]) begin
        last_r  = rt.port;
        rt.open = 0;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Downstream subordinate responder and activity monitors
  // ---------------------------------------------------------------------------
  int          aw_delay  = 0;
  bit          hold_aw   = 0;
  logic [1:0]  bresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = 32'h0;
  bit          rs_aw_got, rs_w_got, rs_ar_got;
  int          rs_aw_cnt;
  logic [31:0] aw_log[$];
  logic [31:0] w_log[$];
  logic [31:0] ar_log[$];
  int          aw_hs_n, w_hs_n;
  int          bv_seen[2], rv_seen[2], act_seen[2];
  int          cyc = 0;
  int          first_req = -1, first_fwd = -1;

  always begin
    @(negedge clk);
    cyc++;
    compare_cycle();
    for (int p = 0; p < 2; p++) begin
      bv_seen[p] += int'(s_bvalid[p]);
      rv_seen[p] += int'(s_rvalid[p]);
      if (s_awready[p] || s_wready[p] || s_arready[p] || s_bvalid[p] || s_rvalid[p])
        act_seen[p]++;
    end
    if (s_awvalid[0] && first_req < 0) first_req = cyc;
    if (m_awvalid && first_fwd < 0)    first_fwd = cyc;
    if (reset_i) begin
      rs_aw_got = 0; rs_w_got = 0; rs_ar_got = 0; rs_aw_cnt = 0;
    end else begin
      if (m_awvalid && m_awready) begin
        aw_log.push_back(m_awaddr); aw_hs_n++; rs_aw_got = 1; rs_aw_cnt = 0;
      end else if (m_awvalid) begin
        rs_aw_cnt++;
      end
      if (m_wvalid && m_wready) begin
        w_log.push_back(m_wdata); w_hs_n++; rs_w_got = 1;
      end
      if (m_bvalid && m_bready) begin
        rs_aw_got = 0; rs_w_got = 0;
      end
      if (m_arvalid && m_arready) begin
        ar_log.push_back(m_araddr); rs_ar_got = 1;
      end
      if (m_rvalid && m_rready) rs_ar_got = 0;
    end
    @(posedge clk);
    #1;
    m_awready = !rs_aw_got && !hold_aw && (rs_aw_cnt >= aw_delay);
    m_wready  = !rs_w_got;
    m_bvalid  = rs_aw_got && rs_w_got;
    m_bresp   = bresp_cfg;
    m_arready = !rs_ar_got;
    m_rvalid  = rs_ar_got;
    m_rdata   = rdata_cfg;
    m_rresp   = 2'b00;
  end

  // ---------------------------------------------------------------------------
  // Upstream manager tasks (drive at posedge+1, observe at negedge)
  // ---------------------------------------------------------------------------
  localparam int budget_lp = 60;

  task automatic do_write(input int p, input logic [31:0] a, input logic [31:0] d,
                          input int w_lead, output logic [1:0] resp);
    bit aw_ok = 0, w_ok = 0, b_ok = 0;
    int n = 0;
    resp = 2'bxx;
    s_awaddr[p] = a; s_awprot[p] = 3'(p + 1);
    s_wdata[p]  = d; s_wstrb[p]  = 4'hF;
    if (w_lead > 0) begin
      s_wvalid[p] = 1'b1;
      for (int i = 0; i < w_lead; i++) begin
        @(negedge clk);
        check($sformatf("s%0d_wready_before_aw", p), s_wready[p], 1'b0);
        @(posedge clk); #1;
      end
    end
    s_awvalid[p] = 1'b1;
    s_wvalid[p]  = 1'b1;
    while (!(aw_ok && w_ok) && n < budget_lp) begin
      @(negedge clk); n++;
      if (s_awvalid[p] && s_awready[p]) aw_ok = 1;
      if (s_wvalid[p]  && s_wready[p])  w_ok  = 1;
      @(posedge clk); #1;
      if (aw_ok) s_awvalid[p] = 1'b0;
      if (w_ok)  s_wvalid[p]  = 1'b0;
    end
    s_bready[p] = 1'b1;
    while (!b_ok && n < budget_lp) begin
      @(negedge clk); n++;
      if (s_bvalid[p]) begin b_ok = 1; resp = s_bresp[p]; end
      @(posedge clk); #1;
    end
    s_bready[p] = 1'b0; s_awvalid[p] = 1'b0; s_wvalid[p] = 1'b0;
    check($sformatf("s%0d_write_completes", p), b_ok, 1'b1);
  endtask

  task automatic do_read(input int p, input logic [31:0] a,
                         output logic [31:0] data, output logic [1:0] resp);
    bit ar_ok = 0, r_ok = 0;
    int n = 0;
    data = 'x; resp = 'x;
    s_araddr[p] = a; s_arprot[p] = 3'(p + 4);
    s_arvalid[p] = 1'b1;
    while (!ar_ok && n < budget_lp) begin
      @(negedge clk); n++;
      if (s_arready[p]) ar_ok = 1;
      @(posedge clk); #1;
    end
    s_arvalid[p] = 1'b0;
    s_rready[p]  = 1'b1;
    while (!r_ok && n < budget_lp) begin
      @(negedge clk); n++;
      if (s_rvalid[p]) begin r_ok = 1; data = s_rdata[p]; resp = s_rresp[p]; end
      @(posedge clk); #1;
    end
    s_rready[p] = 1'b0;
    check($sformatf("s%0d_read_completes", p), r_ok, 1'b1);
  endtask

  task automatic clear_logs();
    aw_log.delete(); w_log.delete(); ar_log.delete();
    aw_hs_n = 0; w_hs_n = 0;
    for (int p = 0; p < 2; p++) begin bv_seen[p] = 0; rv_seen[p] = 0; act_seen[p] = 0; end
    first_req = -1; first_fwd = -1;
  endtask

  task automatic settle(input int cycles);
    repeat (cycles) begin @(posedge clk); #1; end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  logic [1:0]  r0, r1;
  logic [31:0] rd;
  logic [1:0]  rr;
  logic [31:0] exp_addr;

  initial begin
    reset_i = 1'b1;
    for (int p = 0; p < 2; p++) begin
      s_awaddr[p] = '0; s_awprot[p] = '0; s_awvalid[p] = 0;
      s_wdata[p]  = '0; s_wstrb[p]  = '0; s_wvalid[p]  = 0; s_bready[p] = 0;
      s_araddr[p] = '0; s_arprot[p] = '0; s_arvalid[p] = 0; s_rready[p] = 0;
    end
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
    m_arready = 0; m_rvalid = 0; m_rdata  = 0; m_rresp = 0;

    // Pin the round-robin rule used by the model.
    check("pick_tie_after_reset", rr_pick(1, 1, 1), 0);
    check("pick_tie_after_s00",   rr_pick(1, 1, 0), 1);
    check("pick_lone_s01",        rr_pick(0, 1, 1), 1);

    settle(3);
    reset_i = 1'b0;
    settle(1);
    clear_logs();

    // Simultaneous requests, four rounds each: grants alternate from s00.
    fork
      begin
        for (int i = 0; i < 4; i++) do_write(0, 32'h1000_0000 + 32'(i * 16), 32'hA000_0000 + 32'(i), 0, r0);
      end
      begin
        for (int i = 0; i < 4; i++) do_write(1, 32'h1100_0000 + 32'(i * 16), 32'hB000_0000 + 32'(i), 0, r1);
      end
    join
    check("alt_count", aw_log.size(), 8);
    for (int i = 0; i < 8; i++) begin
      exp_addr = ((i % 2) == 0 ? 32'h1000_0000 : 32'h1100_0000) + 32'((i / 2) * 16);
      if (i < aw_log.size()) check($sformatf("alt_addr_%0d", i), aw_log[i], exp_addr);
    end
    settle(2);
    clear_logs();

    // Single s00 write with m00 always ready.
    do_write(0, 32'h2000_0004, 32'hDEAD_BEEF, 0, r0);
    check("single_aw_count", aw_log.size(), 1);
    if (aw_log.size() > 0) check("single_awaddr", aw_log[0], 32'h2000_0004);
    if (w_log.size() > 0)  check("single_wdata",  w_log[0],  32'hDEAD_BEEF);
    check("single_bresp", r0, 2'b00);
    check("single_fwd_latency", first_fwd - first_req, 1);
    check("single_s01_quiet", act_seen[1], 0);
    settle(2);

    // s01: W two cycles ahead of AW, downstream awready held off 3 cycles.
    @(negedge clk); aw_delay = 3;
    @(posedge clk); #1;
    clear_logs();
    do_write(1, 32'h2000_0010, 32'hCAFE_F00D, 2, r1);
    check("wfirst_aw_once", aw_hs_n, 1);
    check("wfirst_w_once",  w_hs_n, 1);
    check("wfirst_b_s01",   bv_seen[1], 1);
    check("wfirst_b_s00",   bv_seen[0], 0);
    check("wfirst_bresp",   r1, 2'b00);
    @(negedge clk); aw_delay = 0; rdata_cfg = 32'h1234_5678;
    @(posedge clk); #1;
    clear_logs();

    // Concurrent s00 write and s01 read.
    fork
      do_write(0, 32'h2000_0000, 32'h0BAD_F00D, 0, r0);
      do_read(1, 32'h2000_0008, rd, rr);
    join
    check("conc_rdata", rd, 32'h1234_5678);
    check("conc_rresp", rr, 2'b00);
    check("conc_r_s00", rv_seen[0], 0);
    check("conc_r_s01", rv_seen[1], 1);
    if (ar_log.size() > 0) check("conc_araddr", ar_log[0], 32'h2000_0008);
    if (aw_log.size() > 0) check("conc_awaddr", aw_log[0], 32'h2000_0000);
    check("conc_bresp", r0, 2'b00);

    // SLVERR passes through untouched (s00, which leaves last_wgrant = s00).
    @(negedge clk); bresp_cfg = 2'b10;
    @(posedge clk); #1;
    do_write(0, 32'h2000_0020, 32'h5555_AAAA, 0, r0);
    check("slverr_bresp", r0, 2'b10);
    @(negedge clk); bresp_cfg = 2'b00; hold_aw = 1;
    @(posedge clk); #1;

    // Reset in the middle of a write address phase.
    s_awaddr[0] = 32'h2000_0030; s_awprot[0] = 3'd1; s_awvalid[0] = 1'b1;
    settle(2);
    @(negedge clk);
    check("rst_busy_awvalid", m_awvalid, 1'b1);
    @(posedge clk); #1;
    reset_i = 1'b1;
    settle(1);
    @(negedge clk);
    check("rst_m_awvalid", m_awvalid, 1'b0);
    check("rst_m_wvalid",  m_wvalid,  1'b0);
    check("rst_m_arvalid", m_arvalid, 1'b0);
    check("rst_m_bready",  m_bready,  1'b0);
    check("rst_m_rready",  m_rready,  1'b0);
    check("rst_s0_awready", s_awready[0], 1'b0);
    check("rst_s0_bvalid",  s_bvalid[0],  1'b0);
    hold_aw = 0;
    @(posedge clk); #1;
    reset_i = 1'b0; s_awvalid[0] = 1'b0;
    clear_logs();
    fork
      do_write(0, 32'h2000_0100, 32'h1111_1111, 0, r0);
      do_write(1, 32'h2000_0200, 32'h2222_2222, 0, r1);
    join
    check("post_rst_count", aw_log.size(), 2);
    if (aw_log.size() > 0) check("post_rst_s00_first", aw_log[0], 32'h2000_0100);
    settle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end (checks=%0d)", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
